// File: rtl/demux_1_to_4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel valid flags, write strobe and overwrite report.
// Optional macro LOAD_EDGE_DETECT_EN: write on the rising edge of load instead of on its level.
module demux_1_to_4_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] inDemux,
  input  logic             load,
  input  logic             clear,
  output logic [WIDTH-1:0] outDemux0,
  output logic [WIDTH-1:0] outDemux1,
  output logic [WIDTH-1:0] outDemux2,
  output logic [WIDTH-1:0] outDemux3,
  output logic [3:0]       valid,
  output logic [1:0]       lastSel,
  output logic             wrStrobe,
  output logic             overwrite
);

  logic loadQ_r;
  logic we_s;

  // Write-event qualification: rising edge of load or plain level, depending on build.
  always_comb begin
    we_s = 1'b0;
`ifdef LOAD_EDGE_DETECT_EN
    we_s = load & ~loadQ_r;
`else
    we_s = load;
`endif
  end

`ifndef LOAD_EDGE_DETECT_EN
  // In the level build the sampled load is kept only for structural parity with the edge build.
  logic unusedLoadQ_s;
  assign unusedLoadQ_s = loadQ_r;
`endif

  // Previous-cycle load sample; keeps updating through clear so a coincident edge is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loadQ_r <= 1'b0;
    end else begin
      loadQ_r <= load;
    end
  end

  // Channel registers, flags and status pulses: clear beats write, write beats hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outDemux0 <= {WIDTH{1'b0}};
      outDemux1 <= {WIDTH{1'b0}};
      outDemux2 <= {WIDTH{1'b0}};
      outDemux3 <= {WIDTH{1'b0}};
      valid     <= 4'b0000;
      lastSel   <= 2'd0;
      wrStrobe  <= 1'b0;
      overwrite <= 1'b0;
    end else if (clear) begin
      outDemux0 <= {WIDTH{1'b0}};
      outDemux1 <= {WIDTH{1'b0}};
      outDemux2 <= {WIDTH{1'b0}};
      outDemux3 <= {WIDTH{1'b0}};
      valid     <= 4'b0000;
      lastSel   <= 2'd0;
      wrStrobe  <= 1'b0;
      overwrite <= 1'b0;
    end else if (we_s) begin
      case (select)
        2'd0:    outDemux0 <= inDemux;
        2'd1:    outDemux1 <= inDemux;
        2'd2:    outDemux2 <= inDemux;
        2'd3:    outDemux3 <= inDemux;
        default: outDemux0 <= outDemux0;
      endcase
      valid[select] <= 1'b1;
      lastSel       <= select;
      wrStrobe      <= 1'b1;
      // Flag reflects the channel state before this write lands.
      overwrite     <= valid[select];
    end else begin
      wrStrobe  <= 1'b0;
      overwrite <= 1'b0;
    end
  end

endmodule

// File: doc/demux_1_to_4_reg.md
# demux_1_to_4_reg

Registered 1-to-4 demultiplexer: routes one WIDTH-bit data word, chosen by a 2-bit select, into one of four holding registers on a write strobe. All other channels keep their values. It is the write-side counterpart of the 4-to-1 select mux: it scatters switch data into four banks that the mux later gathers back. Each channel has a valid flag, and the block reports overwrites of data that was already valid.

## Interface
Parameters:
- WIDTH, 4, data width of input and each output channel

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- select  input  2  destination channel index (0..3)
- inDemux  input  WIDTH  data word to store
- load  input  1  write request (level or edge, see Configuration)
- clear  input  1  synchronous clear of all channels and flags
- outDemux0..outDemux3  output  WIDTH each  registered channel contents
- valid  output  4  valid[N]=1 once channel N has been written since last clear/reset
- lastSel  output  2  index of the most recently written channel
- wrStrobe  output  1  one-cycle pulse, high in the cycle after a write is committed
- overwrite  output  1  one-cycle pulse, high together with wrStrobe when the written channel was already valid

## Operation
- Write event (we):
  - with the macro defined: load & ~load_q
  - without the macro: load
  - load_q is a 1-bit register that samples load every cycle.
- Priority at each rising clk, highest first: rst_n low, then clear, then we, then hold.
- Clear:
  - outDemux0..3 <= 0, valid <= 4'b0000, lastSel <= 0
  - wrStrobe <= 0, overwrite <= 0
  - load_q still updates, so a rising edge that coincides with clear is consumed and does not cause a later write.
- Write to channel N = select:
  - outDemuxN <= inDemux
  - valid[N] <= 1
  - lastSel <= N
  - wrStrobe <= 1
  - overwrite <= valid[N], using the value before this edge
- Unselected channels and their valid bits hold.
- No write: wrStrobe <= 0 and overwrite <= 0. All other outputs hold.
- select and inDemux are sampled only on the write edge. Changing them between writes has no effect.
- A write with identical data to a valid channel still counts as an overwrite.
- There is no default or fallback channel. All four select codes are legal.

## Timing
- Reset (asynchronous, rst_n low) sets:
  - outDemux0..3 = 0
  - valid = 0
  - lastSel = 0
  - wrStrobe = 0
  - overwrite = 0
  - load_q = 0
- Reset is asynchronous on assertion. Deassertion is assumed synchronous to clk upstream.
- Latency: data presented at edge k with we=1 appears on outDemuxN after edge k. wrStrobe and overwrite are high for exactly the cycle between edge k and edge k+1.
- Edge mode, load already high when rst_n deasserts: load_q=0, so the first edge performs one write.
- Edge mode, load held high: exactly one write. The next write needs load to go low for at least one sampled cycle.
- Level mode, load held high for M cycles: M writes. The first sets wrStrobe with overwrite=valid[N]. The following M-1 writes all report overwrite=1 on the same channel.
- Reset mid-operation: all state returns to reset values immediately, with no partial write.
- Every output comes directly from a flop. There are no combinational paths from inputs to outputs.

## Configuration
- LOAD_EDGE_DETECT_EN
  - Defined: we = rising edge of load, one write per press. This is the board-button usage.
  - Undefined: we = load level, one write per cycle while high. This is the testbench and streaming usage.
- load_q exists in both builds. Without the macro it only tracks load and is otherwise unused.

## Test plan
- Reset release: rst_n low then high. Required: all outputs 0, valid=0000, wrStrobe=0.
- Scatter: writes with (select,data) = (0,4'h3), (1,4'hA), (2,4'h5), (3,4'hF). Required: outDemux0..3 = 3/A/5/F, valid=1111, lastSel=3, four wrStrobe pulses, overwrite never high.
- Overwrite: after the scatter, write (2,4'h9). Required: outDemux2=9, other channels unchanged, wrStrobe=1 and overwrite=1 for one cycle.
- Clear priority: assert clear and a load rising edge in the same cycle with (1,4'h7). Required: all channels 0, valid=0000, no wrStrobe then or in the following cycles while load stays high (edge build).
- Load held (edge build): load high for 5 cycles with select=0, data=4'hC. Required: one wrStrobe, outDemux0=C, overwrite=0. In the level build the same stimulus gives 5 wrStrobe pulses, overwrite high on the last 4.
- Async reset mid-run: drop rst_n between clock edges after the scatter. Required: outputs clear before the next clk edge. After release, valid=0000.
